deframing_crc: RTL
==================

# deframing_crc

Receive-side counterpart of the framing/CRC transmitter in the framing_encoding chain. Consumes the transmitter's cycle stream and performs these steps:
- Hunts for the SHR (0xAA preamble, then the 0xF3/0x98 SFD).
- Recovers the PHR and PSDU bytes and the bit-serial CRC-16 over them.
- Compares the recovered CRC against the received FCS.
- Presents payload bytes and a per-frame CRC verdict to the downstream decoder.

## Interface
- MIN_PREAMBLE, 32: consecutive 0xAA cycles required before the SFD is accepted (1..64).
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- din  input  8  line byte, one per cycle; each PHR/PSDU/FCS byte is held for 8 cycles, one cycle per bit
- dout  output  8  recovered PHR or PSDU byte; valid only with dout_valid
- dout_valid  output  1  one-cycle pulse per recovered PHR/PSDU byte
- frame_end  output  1  one-cycle pulse when a frame finishes (normal or aborted)
- crc_ok  output  1  CRC verdict; meaningful only while frame_end=1, otherwise 0
- busy  output  1  1 in every state except HUNT

## Operation
- **States:** HUNT, SFD1, SFD2, PHR, PSDU, FCS.
- **Counters:**
  - bit counter `bcnt` (3 bits, 0..7, wraps).
  - run counter `rcnt` (7 bits, saturating at 64).
  - byte counter `left` (7 bits).
- **HUNT:**
  - din==0xAA: rcnt increments (saturating).
  - din==0xF3 and rcnt>=MIN_PREAMBLE: go to SFD1 with rcnt=1.
  - Any other byte: rcnt=0.
- **SFD1:** needs 8 consecutive 0xF3 cycles in total, then expects 0x98.
- **SFD2:** needs 8 consecutive 0x98 cycles, then goes to PHR with bcnt=0 and crc=0xFFFF.
- **SFD mismatch:**
  - Any mismatch in SFD1/SFD2 returns to HUNT with rcnt=(din==0xAA)?1:0.
  - No frame_end is generated.
- **Bit-serial CRC (PHR, PSDU):**
  - Each cycle, bit b=din[bcnt] and c=b^crc[0].
  - crc_next=(crc>>1)^(c?16'h8408:0), i.e. reflected CCITT.
  - The CRC register is 16 bits; no widening.
- **Byte capture:** at bcnt==7, din is taken as the byte value, dout_valid pulses, and bcnt wraps to 0.
- **PHR byte:**
  - L=PHR[6:0] is the frame length including the 2 FCS bytes.
  - L>=3: go to PSDU with left=L-2.
  - L==2: go directly to FCS.
  - L<2: abort to HUNT with frame_end=1, crc_ok=0; the PHR byte is still output.
- **PSDU:** left decrements per byte; after the last byte (left==1 at bcnt==7), go to FCS.
- **FCS:**
  - CRC is frozen; 16 cycles.
  - At bcnt==7 of byte 0, capture fcs_lo; at bcnt==7 of byte 1, capture fcs_hi. FCS bytes are not output on dout.
  - After the 16th cycle, go to HUNT; frame_end=1 and crc_ok=(fcs_lo==~crc[7:0])&&(fcs_hi==~crc[15:8]).
- **Byte stability:** din is not checked within a byte; the CRC uses per-cycle bits, dout uses the bcnt==7 sample.
- **Back-to-back frames:** HUNT resumes in the cycle after the last FCS cycle and can accept a preamble immediately.

## Timing
- **Output registration:** all outputs registered. dout/dout_valid assert the cycle after the bcnt==7 cycle of a byte, for exactly 1 cycle.
- **frame_end/crc_ok:** asserted the cycle after the 16th FCS cycle (or after the aborting PHR cycle), for 1 cycle.
- **Reset:**
  - Outputs: dout=0, dout_valid=0, frame_end=0, crc_ok=0, busy=0.
  - Internal: state=HUNT, rcnt=0, bcnt=0, crc=0xFFFF.
- **Reset mid-frame:** the frame is dropped silently (no frame_end) and any pending output pulse is cancelled.
- **Minimum frame duration:** 80 SHR cycles + 8 PHR + 8·(L−2) PSDU + 16 FCS.
- **busy:** reflects the registered state; rises the cycle after the first SFD byte.

## Test plan
- **Minimal frame:** 64×0xAA, 8×0xF3, 8×0x98, 8×0x02, 8×0x6A, 8×0xD3 -> one dout_valid with dout=0x02, then frame_end=1, crc_ok=1 exactly 1 cycle after the last 0xD3 cycle.
- **Corrupted FCS:** same frame with the last FCS byte 0xD2 -> dout=0x02 pulse, frame_end=1, crc_ok=0.
- **Short preamble:** 16×0xAA then SFD with MIN_PREAMBLE=32 -> stays in HUNT; no dout_valid, no frame_end, busy=0.
- **SFD glitch, then retry:**
  - 64×0xAA, 5×0xF3, 0x00, then a full valid frame.
  - Required: the first attempt is silently dropped; the second frame yields crc_ok=1.
- **Bad length:** PHR=0x01 -> dout=0x01 pulse, then frame_end=1, crc_ok=0; next frame decodes normally.
- **Reset and back-to-back behaviour:**
  - reset=1 for one cycle mid-PSDU -> outputs all 0, no frame_end, busy=0 next cycle.
  - Two back-to-back valid frames with no idle gap -> two frame_end pulses, both with crc_ok=1.

Source files
------------

// File: rtl/deframing_crc_if.sv
`default_nettype none
// ============================================================================
// Module      : deframing_crc_if
// Description : Line-side input and decoder-side outputs of the deframer.
//               master : the source/consumer (drives din, observes outputs)
//               slave  : the deframer (observes din, drives outputs)
//   din        8  line byte, one per cycle
//   dout       8  recovered PHR/PSDU byte (valid with dout_valid)
//   dout_valid 1  one-cycle pulse per recovered byte
//   frame_end  1  one-cycle pulse at end of frame (normal or aborted)
//   crc_ok     1  CRC verdict, meaningful only with frame_end
//   busy       1  deframer is not hunting for a preamble
// Revision    : 1.0 - initial release
// ============================================================================
interface deframing_crc_if;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_end;
  logic       crc_ok;
  logic       busy;

  modport master (
    output din,
    input  dout, dout_valid, frame_end, crc_ok, busy
  );

  modport slave (
    input  din,
    output dout, dout_valid, frame_end, crc_ok, busy
  );
endinterface
`default_nettype wire

// File: rtl/deframing_crc.sv
`default_nettype none
// ============================================================================
// Module      : deframing_crc
// Description : Receive-side deframer. Hunts for the SHR (0xAA preamble run,
//               then 8 cycles of 0xF3 and 8 cycles of 0x98), recovers the
//               PHR and PSDU bytes (each held for 8 cycles, one bit per
//               cycle), runs a bit-serial reflected CCITT CRC-16 over them
//               and checks it against the received FCS.
// Ports       : clk    - clock, all state on rising edge
//               reset  - synchronous active-high reset
//               bus    - deframing_crc_if.slave (din in; dout, dout_valid,
//                        frame_end, crc_ok, busy out)
// Parameters  : MIN_PREAMBLE - 0xAA cycles required before SFD (1..64)
// Revision    : 1.0 - initial release
// ============================================================================
module deframing_crc #(
  parameter int MIN_PREAMBLE = 32
) (
  input  logic            clk,
  input  logic            reset,
  deframing_crc_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_SFD1 = 3'd1,
    S_SFD2 = 3'd2,
    S_PHR  = 3'd3,
    S_PSDU = 3'd4,
    S_FCS  = 3'd5
  } state_t;

  localparam logic [7:0]  C_PREAMBLE = 8'hAA;
  localparam logic [7:0]  C_SFD1     = 8'hF3;
  localparam logic [7:0]  C_SFD2     = 8'h98;
  localparam logic [6:0]  C_MIN_RUN  = 7'(MIN_PREAMBLE);
  localparam logic [6:0]  C_RUN_SAT  = 7'd64;
  localparam logic [15:0] C_CRC_POLY = 16'h8408;
  localparam logic [15:0] C_CRC_INIT = 16'hFFFF;

  state_t      state_q;
  logic [6:0]  rcnt_q;
  logic [2:0]  bcnt_q;
  logic [6:0]  left_q;
  logic [15:0] crc_q;
  logic [7:0]  fcs_lo_q;
  logic        fcs_hi_sel_q;   // 0: receiving FCS low byte, 1: high byte
  logic [7:0]  dout_q;
  logic        dout_valid_q;
  logic        frame_end_q;
  logic        crc_ok_q;

  logic        fb_d;
  logic [15:0] crc_d;

  // One CRC step on the bit selected by the bit counter.
  always_comb begin
    fb_d  = bus.din[bcnt_q] ^ crc_q[0];
    crc_d = {1'b0, crc_q[15:1]} ^ (fb_d ? C_CRC_POLY : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HUNT;
      rcnt_q       <= 7'd0;
      bcnt_q       <= 3'd0;
      left_q       <= 7'd0;
      crc_q        <= C_CRC_INIT;
      fcs_lo_q     <= 8'h00;
      fcs_hi_sel_q <= 1'b0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      crc_ok_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      crc_ok_q     <= 1'b0;

      case (state_q)
        S_HUNT: begin
          if (bus.din == C_SFD1 && rcnt_q >= C_MIN_RUN) begin
            state_q <= S_SFD1;
            rcnt_q  <= 7'd1;
          end else if (bus.din == C_PREAMBLE) begin
            if (rcnt_q != C_RUN_SAT) rcnt_q <= rcnt_q + 7'd1;
          end else begin
            rcnt_q <= 7'd0;
          end
        end

        // rcnt counts the 0xF3 cycles seen so far; exactly 8 must precede 0x98.
        S_SFD1: begin
          if (bus.din == C_SFD1 && rcnt_q < 7'd8) begin
            rcnt_q <= rcnt_q + 7'd1;
          end else if (bus.din == C_SFD2 && rcnt_q == 7'd8) begin
            state_q <= S_SFD2;
            rcnt_q  <= 7'd1;
          end else begin
            state_q <= S_HUNT;
            rcnt_q  <= (bus.din == C_PREAMBLE) ? 7'd1 : 7'd0;
          end
        end

        // The 8th 0x98 cycle moves straight into the PHR.
        S_SFD2: begin
          if (bus.din == C_SFD2) begin
            if (rcnt_q == 7'd7) begin
              state_q <= S_PHR;
              bcnt_q  <= 3'd0;
              crc_q   <= C_CRC_INIT;
            end else begin
              rcnt_q <= rcnt_q + 7'd1;
            end
          end else begin
            state_q <= S_HUNT;
            rcnt_q  <= (bus.din == C_PREAMBLE) ? 7'd1 : 7'd0;
          end
        end

        S_PHR: begin
          crc_q  <= crc_d;
          bcnt_q <= bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            dout_q       <= bus.din;
            dout_valid_q <= 1'b1;
            if (bus.din[6:0] >= 7'd3) begin
              state_q <= S_PSDU;
              left_q  <= bus.din[6:0] - 7'd2;
            end else if (bus.din[6:0] == 7'd2) begin
              state_q      <= S_FCS;
              fcs_hi_sel_q <= 1'b0;
            end else begin
              // Length too short to hold the FCS: abort with a failed verdict.
              state_q     <= S_HUNT;
              rcnt_q      <= 7'd0;
              frame_end_q <= 1'b1;
            end
          end
        end

        S_PSDU: begin
          crc_q  <= crc_d;
          bcnt_q <= bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            dout_q       <= bus.din;
            dout_valid_q <= 1'b1;
            left_q       <= left_q - 7'd1;
            if (left_q == 7'd1) begin
              state_q      <= S_FCS;
              fcs_hi_sel_q <= 1'b0;
            end
          end
        end

        // CRC is frozen here; the high FCS byte is compared as it arrives.
        S_FCS: begin
          bcnt_q <= bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (!fcs_hi_sel_q) begin
              fcs_lo_q     <= bus.din;
              fcs_hi_sel_q <= 1'b1;
            end else begin
              state_q     <= S_HUNT;
              rcnt_q      <= 7'd0;
              frame_end_q <= 1'b1;
              crc_ok_q    <= (fcs_lo_q == ~crc_q[7:0]) && (bus.din == ~crc_q[15:8]);
            end
          end
        end

        default: begin
          state_q <= S_HUNT;
          rcnt_q  <= 7'd0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.crc_ok     = crc_ok_q;
  assign bus.busy       = (state_q != S_HUNT);

endmodule
`default_nettype wire
